// File: rtl/config_loader_if.sv
// Pin-level bundle of the config loader: external SPI pins on one side and the
// downstream configuration shift-register strobes on the other.
interface config_loader_if;
   logic spiSck;
   logic spiCsN;
   logic spiMosi;
   logic spiMiso;
   logic serialEn;
   logic serialIn;
   logic serialOut;
   logic busy;
   logic frameDone;
   logic frameError;

   modport master (
      output spiSck, spiCsN, spiMosi, serialOut,
      input  spiMiso, serialEn, serialIn, busy, frameDone, frameError
   );

   modport slave (
      input  spiSck, spiCsN, spiMosi, serialOut,
      output spiMiso, serialEn, serialIn, busy, frameDone, frameError
   );
endinterface

// File: rtl/config_loader.sv
// SPI mode-0 slave that streams a fixed-length frame into a downstream config
// shift register and checks the frame length on csN release.
module config_loader #(
   parameter int ShiftRegSize = 16,
   parameter int SyncStages   = 2
) (
   input logic            clk,
   input logic            resetN,
   config_loader_if.slave bus
);
   localparam int CntW = $clog2(ShiftRegSize + 2);
   localparam logic [CntW-1:0] CntFull = CntW'(ShiftRegSize);
   localparam logic [CntW-1:0] CntMax  = CntW'(ShiftRegSize + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_CHECK  = 2'd2
   } state_t;

   logic [SyncStages-1:0] r_sck_sync;
   logic [SyncStages-1:0] r_csn_sync;
   logic [SyncStages-1:0] r_mosi_sync;
   logic                  r_sck_d;
   logic                  r_csn_d;
   logic [SyncStages:0]   r_flush;
   logic                  r_armed;

   state_t          r_state;
   logic [CntW-1:0] r_bit_count;
   logic            r_serial_en;
   logic            r_serial_in;
   logic            r_miso;
   logic            r_busy;
   logic            r_frame_done;
   logic            r_frame_error;

   logic            w_sck_s;
   logic            w_csn_s;
   logic            w_mosi_s;
   logic            w_sck_rise;
   logic            w_sck_fall;
   logic            w_csn_rise;
   logic            w_frame_start;

   state_t          w_state_nxt;
   logic [CntW-1:0] w_cnt_nxt;
   logic            w_en_nxt;
   logic            w_in_nxt;
   logic            w_miso_nxt;
   logic            w_done_nxt;
   logic            w_err_nxt;

   assign w_sck_s    = r_sck_sync[SyncStages-1];
   assign w_csn_s    = r_csn_sync[SyncStages-1];
   assign w_mosi_s   = r_mosi_sync[SyncStages-1];
   assign w_sck_rise = w_sck_s & ~r_sck_d;
   assign w_sck_fall = ~w_sck_s & r_sck_d;
   assign w_csn_rise = w_csn_s & ~r_csn_d;
   // The csN chain resets high, so a pin held low through reset would look like
   // a falling edge; frames start only once a genuine high csN has been seen.
   assign w_frame_start = r_armed & r_csn_d & ~w_csn_s;

   // Pin synchronizers, edge-detect delay flops and post-reset arming
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_sck_sync  <= {SyncStages{1'b0}};
         r_csn_sync  <= {SyncStages{1'b1}};
         r_mosi_sync <= {SyncStages{1'b0}};
         r_sck_d     <= 1'b0;
         r_csn_d     <= 1'b1;
         r_flush     <= {(SyncStages + 1){1'b0}};
         r_armed     <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SyncStages-2:0], bus.spiSck};
         r_csn_sync  <= {r_csn_sync[SyncStages-2:0], bus.spiCsN};
         r_mosi_sync <= {r_mosi_sync[SyncStages-2:0], bus.spiMosi};
         r_sck_d     <= w_sck_s;
         r_csn_d     <= w_csn_s;
         r_flush     <= {r_flush[SyncStages-1:0], 1'b1};
         r_armed     <= r_armed | (r_flush[SyncStages] & w_csn_s);
      end
   end

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_bit_count;
      w_en_nxt    = 1'b0;
      w_in_nxt    = r_serial_in;
      w_miso_nxt  = r_miso;
      w_done_nxt  = 1'b0;
      w_err_nxt   = r_frame_error;
      case (r_state)
         ST_IDLE: begin
            if (w_frame_start) begin
               w_state_nxt = ST_ACTIVE;
               w_cnt_nxt   = {CntW{1'b0}};
               w_err_nxt   = 1'b0;
               w_miso_nxt  = bus.serialOut;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            // csN release wins over a coincident sck rise.
            if (w_csn_rise) begin
               w_state_nxt = ST_CHECK;
               w_done_nxt  = (r_bit_count == CntFull);
               w_err_nxt   = (r_bit_count != CntFull);
            end else if (w_sck_rise && !w_csn_s) begin
               w_en_nxt = 1'b1;
               w_in_nxt = w_mosi_s;
               if (r_bit_count != CntMax) begin
                  w_cnt_nxt = r_bit_count + CntW'(1);
               end else begin
                  w_cnt_nxt = CntMax;
               end
            end else if (w_sck_fall) begin
               w_miso_nxt = bus.serialOut;
            end else begin
               w_state_nxt = ST_ACTIVE;
            end
         end
         ST_CHECK: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state       <= ST_IDLE;
         r_bit_count   <= {CntW{1'b0}};
         r_serial_en   <= 1'b0;
         r_serial_in   <= 1'b0;
         r_miso        <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_bit_count   <= w_cnt_nxt;
         r_serial_en   <= w_en_nxt;
         r_serial_in   <= w_in_nxt;
         r_miso        <= w_miso_nxt;
         r_busy        <= (w_state_nxt != ST_IDLE);
         r_frame_done  <= w_done_nxt;
         r_frame_error <= w_err_nxt;
      end
   end

   assign bus.spiMiso    = r_miso & ~w_csn_s;
   assign bus.serialEn   = r_serial_en;
   assign bus.serialIn   = r_serial_in;
   assign bus.busy       = r_busy;
   assign bus.frameDone  = r_frame_done;
   assign bus.frameError = r_frame_error;
endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with a behavioural 16-bit downstream shift
// register and pin-level SPI mode-0 stimulus.
module tb_config_loader;
   logic clk = 1'b0;
   logic resetN;

   config_loader_if bus ();

   config_loader #(.ShiftRegSize(16), .SyncStages(2)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Downstream config shift register
   logic [15:0] ds_sr;
   logic        ds_load;
   logic [15:0] ds_init;
   always @(posedge clk) begin
      if (ds_load) ds_sr <= ds_init;
      else if (bus.serialEn) ds_sr <= {ds_sr[14:0], bus.serialIn};
   end
   assign bus.serialOut = ds_sr[15];

   // Output monitor: pulse counts, serialIn history, pulse-shape violations
   int          en_cnt   = 0;
   int          done_cnt = 0;
   int          viol     = 0;
   logic [31:0] en_bits  = 32'h0;
   logic        prev_en  = 1'b0;
   always @(negedge clk) begin
      if (bus.serialEn === 1'b1) begin
         en_cnt++;
         en_bits = {en_bits[30:0], bus.serialIn};
         if (prev_en || bus.busy !== 1'b1) viol++;
      end
      if (bus.frameDone === 1'b1) done_cnt++;
      prev_en = (bus.serialEn === 1'b1);
   end

   task automatic frame_open();
      bus.spiCsN = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic send_bits(input logic [31:0] d, input int n, output logic [31:0] mb);
      mb = 32'h0;
      for (int i = n - 1; i >= 0; i--) begin
         bus.spiMosi = d[i];
         repeat (8) @(negedge clk);
         mb = {mb[30:0], bus.spiMiso};
         bus.spiSck = 1'b1;
         repeat (8) @(negedge clk);
         bus.spiSck = 1'b0;
      end
      bus.spiMosi = 1'b0;
   endtask

   task automatic frame_close();
      repeat (8) @(negedge clk);
      bus.spiCsN = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   function automatic logic [31:0] outs_vec();
      return 32'({bus.serialEn, bus.serialIn, bus.busy, bus.spiMiso, bus.frameDone, bus.frameError});
   endfunction

   initial begin
      int          bad;
      int          base_en;
      int          base_done;
      logic [31:0] mb;

      resetN      = 1'b0;
      bus.spiSck  = 1'b0;
      bus.spiCsN  = 1'b1;
      bus.spiMosi = 1'b0;
      ds_load     = 1'b1;
      ds_init     = 16'h0000;
      repeat (3) @(negedge clk);
      check_eq("reset_outs", outs_vec(), 32'h0);

      ds_load = 1'b0;
      resetN  = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.serialEn !== 1'b0 || bus.busy !== 1'b0 || bus.spiMiso !== 1'b0 ||
             bus.frameError !== 1'b0) bad++;
      end
      check_eq("idle_100", 32'(bad), 32'h0);

      // 16-bit write 0xA5C3
      base_en = en_cnt; base_done = done_cnt;
      frame_open();
      check_eq("f1_busy", 32'(bus.busy), 32'h1);
      send_bits(32'h0000_A5C3, 16, mb);
      frame_close();
      check_eq("f1_pulses", 32'(en_cnt - base_en), 32'd16);
      check_eq("f1_bits", {16'h0, en_bits[15:0]}, 32'h0000_A5C3);
      check_eq("f1_done", 32'(done_cnt - base_done), 32'd1);
      check_eq("f1_err", 32'(bus.frameError), 32'h0);
      check_eq("f1_busy_end", 32'(bus.busy), 32'h0);

      // Readback of downstream defaults 0x318F
      ds_init = 16'h318F;
      ds_load = 1'b1;
      @(negedge clk);
      ds_load = 1'b0;
      base_done = done_cnt;
      frame_open();
      send_bits(32'h0, 16, mb);
      frame_close();
      check_eq("rb_miso", mb, 32'h0000_318F);
      check_eq("rb_done", 32'(done_cnt - base_done), 32'd1);

      // 15-bit frame, then a clean 16-bit frame
      base_en = en_cnt; base_done = done_cnt;
      frame_open();
      send_bits(32'h0000_1234, 15, mb);
      frame_close();
      check_eq("short_pulses", 32'(en_cnt - base_en), 32'd15);
      check_eq("short_err", 32'(bus.frameError), 32'h1);
      check_eq("short_done", 32'(done_cnt - base_done), 32'd0);
      base_done = done_cnt;
      frame_open();
      check_eq("err_cleared", 32'(bus.frameError), 32'h0);
      send_bits(32'h0000_BEEF, 16, mb);
      frame_close();
      check_eq("after_short_done", 32'(done_cnt - base_done), 32'd1);
      check_eq("after_short_err", 32'(bus.frameError), 32'h0);

      // 20-bit frame saturates the counter
      base_en = en_cnt; base_done = done_cnt;
      frame_open();
      send_bits(32'h000F_ACE5, 20, mb);
      repeat (4) @(negedge clk);
      check_eq("long_count_sat", 32'(dut.r_bit_count), 32'd17);
      frame_close();
      check_eq("long_pulses", 32'(en_cnt - base_en), 32'd20);
      check_eq("long_err", 32'(bus.frameError), 32'h1);
      check_eq("long_done", 32'(done_cnt - base_done), 32'd0);

      // Reset mid-frame with csN still low at release
      frame_open();
      send_bits(32'h0000_00FF, 8, mb);
      resetN = 1'b0;
      #1;
      check_eq("midrst_outs", outs_vec(), 32'h0);
      repeat (2) @(negedge clk);
      base_en = en_cnt;
      resetN = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("cs_low_release_busy", 32'(bus.busy), 32'h0);
      check_eq("cs_low_release_pulses", 32'(en_cnt - base_en), 32'd0);
      bus.spiCsN = 1'b1;
      repeat (10) @(negedge clk);
      base_en = en_cnt; base_done = done_cnt;
      frame_open();
      send_bits(32'h0000_5A3C, 16, mb);
      frame_close();
      check_eq("post_rst_pulses", 32'(en_cnt - base_en), 32'd16);
      check_eq("post_rst_bits", {16'h0, en_bits[15:0]}, 32'h0000_5A3C);
      check_eq("post_rst_done", 32'(done_cnt - base_done), 32'd1);
      check_eq("post_rst_err", 32'(bus.frameError), 32'h0);

      check_eq("en_shape_viol", 32'(viol), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter ShiftRegSize, default 16, meaning the configuration frame length in bits; it equals the downstream config shift register length.
REQ-002 SHALL have parameter SyncStages, default 2, meaning the synchronizer depth on each external pin; legal range is 2 or more.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 resetN  input  1  asynchronous active-low reset.
REQ-005 spiSck  input  1  external serial clock (SPI mode 0), asynchronous to clk.
REQ-006 spiCsN  input  1  external frame select, active-low, asynchronous.
REQ-007 spiMosi  input  1  external serial data in, MSB first, asynchronous.
REQ-008 spiMiso  output  1  external serial readback data.
REQ-009 serialEn  output  1  shift-enable pulse to the config shift register.
REQ-010 serialIn  output  1  data bit to the config shift register, valid while serialEn=1.
REQ-011 serialOut  input  1  MSB of the config shift register.
REQ-012 busy  output  1  high while a frame is open.
REQ-013 frameDone  output  1  one-cycle pulse marking a correct-length frame.
REQ-014 frameError  output  1  sticky flag marking a wrong-length frame.

Function
REQ-015 spiSck, spiCsN and spiMosi SHALL each pass through a SyncStages-deep flop chain; chain reset values are sck 0, csN 1, mosi 0.
REQ-016 Edges SHALL be detected on synchronized signals only, by comparing the last stage with a registered delayed copy.
REQ-017 The FSM SHALL have states IDLE, ACTIVE and CHECK; reset state is IDLE.
REQ-018 IDLE -> ACTIVE on a synchronized csN falling edge: bitCount cleared to 0, frameError cleared, busy=1.
REQ-019 ACTIVE: each synchronized sck rising edge with synchronized csN=0 SHALL produce a serialEn pulse in the next clk cycle, exactly one cycle wide, with serialIn = synchronized mosi captured at that edge.
REQ-020 ACTIVE: bitCount SHALL increment per accepted rising edge and saturate at ShiftRegSize+1; width is clog2(ShiftRegSize+2).
REQ-021 ACTIVE -> CHECK on a synchronized csN rising edge; an sck rising edge detected in that same cycle SHALL be ignored (no serialEn, no count).
REQ-022 CHECK SHALL last one cycle and then go to IDLE with busy=0.
  - If bitCount==ShiftRegSize: frameDone=1 for that cycle.
  - Otherwise, including 0 bits: frameError=1, held until the next frame start or reset.
REQ-023 spiMiso SHALL come from register misoReg.
  - misoReg loads serialOut on a csN falling edge and on each synchronized sck falling edge while ACTIVE.
  - While synchronized csN=1, spiMiso SHALL be 0.
REQ-024 Total latency from a pin sck rising edge to serialEn SHALL be SyncStages+1 clk cycles.
REQ-025 The sck high and low phases SHALL each be at least SyncStages+3 clk cycles; shorter phases are out of specification and edges may be lost.
REQ-026 serialEn SHALL never be asserted in IDLE or CHECK.

Reset
REQ-027 While resetN=0, immediately and without a clock edge: FSM=IDLE, bitCount=0, serialEn=0, serialIn=0, spiMiso=0, misoReg=0, busy=0, frameDone=0, frameError=0, and synchronizers at their REQ-015 values.
REQ-028 Reset mid-frame SHALL abandon the frame with no frameDone and no frameError; bits already shifted downstream are not restored by this block.
REQ-029 Reset release SHALL be synchronous to clk at the integration level; a csN already low at release SHALL NOT start a frame until a fresh csN falling edge is seen.

Verification
REQ-030 Reset release with pins idle (csN=1, sck=0) -> for 100 cycles serialEn=0, busy=0, spiMiso=0, frameError=0.
REQ-031 16-bit frame 0xA5C3, MSB first, sck phase 8 clk -> 16 serialEn pulses, serialIn sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, one frameDone pulse, frameError=0.
REQ-032 Downstream holds its defaults 0x318F, readback frame with mosi=0 -> spiMiso bits sampled on sck rising edges are 0,0,1,1,0,0,0,1,1,0,0,0,1,1,1,1.
REQ-033 15-bit frame -> frameError=1 and no frameDone; the next csN falling edge clears frameError; a following 16-bit frame gives frameDone.
REQ-034 20-bit frame -> 20 serialEn pulses, bitCount saturates at 17, frameError=1.
REQ-035 resetN pulsed low after 8 bits of a frame -> all outputs at reset values immediately; a new 16-bit frame gives 16 pulses and frameDone.
